dsp_vrp: RTL and testbench
==========================

DSP_VRP -- requirements
Module: dsp_vrp

Interface
REQ-001 SHALL have parameter MODE, default 0, 0: destination-routed, 1: round-robin to any ready output.
REQ-002 SHALL have parameter HSK_MODE, default 1, 0: pass-through, 1: one registered entry per output.
REQ-003 SHALL have parameter WIDTH, default 4, number of output ports (2..32).
REQ-004 SHALL have parameter PLD_WIDTH, default 32, payload bits.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port vld_s  input  1  input beat valid.
REQ-008 SHALL have port rdy_s  output  1  input beat accepted when vld_s & rdy_s.
REQ-009 SHALL have port pld_s  input  PLD_WIDTH  input payload.
REQ-010 SHALL have port dst_s  input  WIDTH  one-hot destination, used in MODE 0 only.
REQ-011 SHALL have port v_vld_m  output  WIDTH  per-output valid.
REQ-012 SHALL have port v_rdy_m  input  WIDTH  per-output ready.
REQ-013 SHALL have port v_pld_m  output  PLD_WIDTH x WIDTH unpacked array  per-output payload.
REQ-014 SHALL have port drop_cnt  output  16  count of beats discarded due to zero dst_s.

Function
REQ-015 SHALL define slot_rdy[i] = v_rdy_m[i] for HSK_MODE 0, and slot_rdy[i] = ~full[i] | v_rdy_m[i] for HSK_MODE 1.
REQ-016 MODE 0: SHALL decode dst_s to sel by lowest set bit when multi-hot; rdy_s = |(sel & slot_rdy).
REQ-017 MODE 0, dst_s == 0: SHALL assert rdy_s, discard the beat, and increment drop_cnt by 1, saturating at 16'hFFFF.
REQ-018 MODE 1: SHALL keep a pointer ptr (clog2(WIDTH) bits, reset 0); sel = first i with slot_rdy[i], searching from ptr upward with wrap-around; rdy_s = |slot_rdy.
REQ-019 MODE 1: on handshake to index g, SHALL set ptr to g+1, or to 0 when g = WIDTH-1; ptr SHALL hold otherwise.
REQ-020 MODE 1: SHALL not use dst_s; drop_cnt SHALL stay 0.
REQ-021 MODE 1 with HSK_MODE 0 SHALL be an elaboration error, since valid would depend on ready.
REQ-022 HSK_MODE 0: SHALL drive v_vld_m = {WIDTH{vld_s}} & sel and v_pld_m[i] = pld_s for all i, with zero latency.
REQ-023 HSK_MODE 1: slot i SHALL load pld_s and set full[i] on the cycle of an input handshake with sel[i].
REQ-024 HSK_MODE 1: slot i SHALL clear full[i] on the cycle of an output handshake without a simultaneous load; v_vld_m[i] = full[i]; latency 1 cycle.
REQ-025 HSK_MODE 1: a simultaneous load and drain on one slot SHALL keep full[i]=1 and replace the payload, giving full throughput of 1 beat per cycle per slot.
REQ-026 SHALL never deliver one input beat to more than one output, nor lose a beat (the REQ-017 case excepted).
REQ-027 v_pld_m[i] SHALL hold stable while v_vld_m[i] & ~v_rdy_m[i].

Reset
REQ-028 While rst=1, SHALL force full, ptr, drop_cnt, v_vld_m and all v_pld_m to 0; rdy_s follows the combinational rules above using reset state.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered beats with no output handshake on the next cycle.

Structure
REQ-030 SHALL place the MODE and HSK_MODE encodings as localparams in shared package dsp_pkg.
REQ-031 SHALL implement each per-output register as sub-module dsp_slot (1-entry valid/ready slice, PLD_WIDTH parameter), instantiated WIDTH times under HSK_MODE 1.

Verification
REQ-032 MODE 0/HSK 1, W=4: beats dst=4'b0100 pld=32'hA5, all rdy_m=1 -> v_vld_m=4'b0100 one cycle later, pld 32'hA5, rdy_s=1 every cycle.
REQ-033 MODE 0/HSK 1: v_rdy_m[2]=0, two beats to dst 4'b0100 -> first held in slot 2, rdy_s=0 for the second until rdy_m[2] rises; order is preserved.
REQ-034 MODE 0: dst=4'b0000 for 3 beats -> no v_vld_m, drop_cnt=3; with drop_cnt preset near 16'hFFFF, drop_cnt saturates at 16'hFFFF.
REQ-035 MODE 1/HSK 1, all ready, 8 beats -> targets 0,1,2,3,0,1,2,3; with v_rdy_m=4'b1010 and slots 1,3 full, the 9th beat goes to slot 0.
REQ-036 Simultaneous load and drain on slot 1 for 5 consecutive cycles -> 5 beats out, back-to-back, in order.
REQ-037 rst=1 asserted with 2 slots full -> next cycle v_vld_m=0, ptr=0, drop_cnt=0.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared encodings for the dsp_vrp valid/ready router and a small index helper.
package dsp_pkg;
    localparam int MODE_DST = 0;
    localparam int MODE_RR  = 1;
    localparam int HSK_PASS = 0;
    localparam int HSK_REG  = 1;

    // (a + b) mod n, valid while a < n and b < n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction
endpackage

// File: rtl/dsp_slot.sv
// One-entry valid/ready output register: a load wins over a drain, so a slot
// that is loaded and drained on the same cycle stays full with the new beat.
module dsp_slot
    import dsp_pkg::*;
#(
    parameter int PLD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [PLD_WIDTH-1:0] i_pld,
    input  logic                 i_rdy,
    output logic                 o_full,
    output logic [PLD_WIDTH-1:0] o_pld
);
    logic                 r_full;
    logic [PLD_WIDTH-1:0] r_pld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_pld  <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_pld  <= i_pld;
        end else if (r_full && i_rdy) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_pld  = r_pld;
endmodule

// File: rtl/dsp_vrp.sv
// Single-input, WIDTH-output router: destination-routed or round-robin, with
// either combinational pass-through or one registered slot per output.
module dsp_vrp
    import dsp_pkg::*;
#(
    parameter int MODE      = 0,
    parameter int HSK_MODE  = 1,
    parameter int WIDTH     = 4,
    parameter int PLD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_s,
    output logic                 rdy_s,
    input  logic [PLD_WIDTH-1:0] pld_s,
    input  logic [WIDTH-1:0]     dst_s,
    output logic [WIDTH-1:0]     v_vld_m,
    input  logic [WIDTH-1:0]     v_rdy_m,
    output logic [PLD_WIDTH-1:0] v_pld_m [WIDTH],
    output logic [15:0]          drop_cnt
);
    localparam int PW = $clog2(WIDTH);

    generate
        if (MODE == MODE_RR && HSK_MODE == HSK_PASS) begin : g_bad_cfg
            $error("dsp_vrp: round-robin needs registered outputs, valid would depend on ready");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("dsp_vrp: WIDTH must be in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] w_full;
    logic [WIDTH-1:0] w_slot_rdy;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_sel_dst;
    logic [WIDTH-1:0] w_sel_rr;
    logic [WIDTH-1:0] w_load;
    logic [PW-1:0]    w_rr_idx [WIDTH];
    logic [PW-1:0]    w_gidx;
    logic [PW-1:0]    r_ptr;
    logic [15:0]      r_drop_cnt;
    logic             w_dst_zero;
    logic             w_hs;
    logic             w_drop;

    assign w_slot_rdy = (HSK_MODE == HSK_REG) ? (~w_full | v_rdy_m) : v_rdy_m;

    // Multi-hot destinations collapse to their lowest set bit.
    assign w_dst_zero = ~|dst_s;
    assign w_sel_dst  = dst_s & (~dst_s + WIDTH'(1));

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            w_rr_idx[k] = PW'(wrap_add(int'(r_ptr), k, WIDTH));
        end
    end

    // Walk offsets from far to near so the closest ready slot after ptr wins.
    always_comb begin
        w_sel_rr = '0;
        w_gidx   = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (w_slot_rdy[w_rr_idx[k]]) begin
                w_sel_rr              = '0;
                w_sel_rr[w_rr_idx[k]] = 1'b1;
                w_gidx                = w_rr_idx[k];
            end
        end
    end

    assign w_sel  = (MODE == MODE_RR) ? w_sel_rr : w_sel_dst;
    assign rdy_s  = (MODE == MODE_RR) ? (|w_slot_rdy)
                                      : (w_dst_zero | (|(w_sel & w_slot_rdy)));
    assign w_hs   = vld_s & rdy_s;
    assign w_load = {WIDTH{w_hs}} & w_sel;
    assign w_drop = (MODE == MODE_DST) && w_hs && w_dst_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (MODE == MODE_RR && w_hs) begin
            r_ptr <= (w_gidx == PW'(WIDTH - 1)) ? '0 : w_gidx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;

    generate
        if (HSK_MODE == HSK_REG) begin : g_reg
            logic [WIDTH-1:0]     w_slot_full;
            logic [PLD_WIDTH-1:0] w_slot_pld [WIDTH];
            for (genvar i = 0; i < WIDTH; i++) begin : g_slot
                dsp_slot #(.PLD_WIDTH(PLD_WIDTH)) u_slot (
                    .clk    (clk),
                    .rst    (rst),
                    .i_load (w_load[i]),
                    .i_pld  (pld_s),
                    .i_rdy  (v_rdy_m[i]),
                    .o_full (w_slot_full[i]),
                    .o_pld  (w_slot_pld[i])
                );
                // Outputs read as empty for the whole reset window, not just after the edge.
                assign w_full[i]  = w_slot_full[i] & ~rst;
                assign v_vld_m[i] = w_full[i];
                assign v_pld_m[i] = rst ? '0 : w_slot_pld[i];
            end
        end else begin : g_pass
            assign w_full = '0;
            for (genvar i = 0; i < WIDTH; i++) begin : g_out
                assign v_vld_m[i] = vld_s & w_sel[i] & ~rst;
                assign v_pld_m[i] = rst ? '0 : pld_s;
            end
        end
    endgenerate
endmodule

// File: tb/tb_dsp_vrp.sv
// Scoreboard bench: destination-routed and round-robin registered routers plus
// a pass-through instance checked directly.
module tb_dsp_vrp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_vld, a_rdy;
    logic [31:0] a_pld;
    logic [3:0]  a_dst, a_vvld, a_vrdy;
    logic [31:0] a_vpld [4];
    logic [15:0] a_drop;

    logic        b_vld, b_rdy;
    logic [31:0] b_pld;
    logic [3:0]  b_dst, b_vvld, b_vrdy;
    logic [31:0] b_vpld [4];
    logic [15:0] b_drop;

    logic        c_vld, c_rdy;
    logic [31:0] c_pld;
    logic [3:0]  c_dst, c_vvld, c_vrdy;
    logic [31:0] c_vpld [4];
    logic [15:0] c_drop;

    dsp_vrp #(.MODE(0), .HSK_MODE(1), .WIDTH(4), .PLD_WIDTH(32)) u0 (
        .clk(clk), .rst(rst), .vld_s(a_vld), .rdy_s(a_rdy), .pld_s(a_pld), .dst_s(a_dst),
        .v_vld_m(a_vvld), .v_rdy_m(a_vrdy), .v_pld_m(a_vpld), .drop_cnt(a_drop));

    dsp_vrp #(.MODE(1), .HSK_MODE(1), .WIDTH(4), .PLD_WIDTH(32)) u1 (
        .clk(clk), .rst(rst), .vld_s(b_vld), .rdy_s(b_rdy), .pld_s(b_pld), .dst_s(b_dst),
        .v_vld_m(b_vvld), .v_rdy_m(b_vrdy), .v_pld_m(b_vpld), .drop_cnt(b_drop));

    dsp_vrp #(.MODE(0), .HSK_MODE(0), .WIDTH(4), .PLD_WIDTH(32)) u2 (
        .clk(clk), .rst(rst), .vld_s(c_vld), .rdy_s(c_rdy), .pld_s(c_pld), .dst_s(c_dst),
        .v_vld_m(c_vvld), .v_rdy_m(c_vrdy), .v_pld_m(c_vpld), .drop_cnt(c_drop));

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] pld;
    } exp_t;

    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;
    int   rr_ports [6] = '{0, 1, 2, 3, 1, 3};

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, got, req);
        end
    endfunction

    function automatic void pop_check(input int d, input int p, input logic [31:0] got);
        int idx = -1;
        for (int k = 0; k < sbq.size(); k++)
            if (idx < 0 && sbq[k].dut == d && sbq[k].port == p) idx = k;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL out_unexpected dut%0d port%0d got %h required none", d, p, got);
        end else begin
            if (sbq[idx].pld !== got) begin
                errors++;
                $display("FAIL out_pld dut%0d port%0d got %h required %h", d, p, got, sbq[idx].pld);
            end
            sbq.delete(idx);
        end
    endfunction

    // Monitor: every output handshake must match the oldest expected beat for that port.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (a_vvld[i] && a_vrdy[i]) pop_check(0, i, a_vpld[i]);
                if (b_vvld[i] && b_vrdy[i]) pop_check(1, i, b_vpld[i]);
            end
        end
    end

    task automatic send(input int d, input logic [3:0] dst, input logic [31:0] pld,
                        input int exp_port, input bit expect_now);
        int n   = 0;
        bit acc = 1'b0;
        if (d == 0) begin a_vld = 1'b1; a_dst = dst; a_pld = pld; end
        else        begin b_vld = 1'b1; b_dst = dst; b_pld = pld; end
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = (d == 0) ? a_rdy : b_rdy;
            if (acc && exp_port >= 0) sbq.push_back(exp_t'{d, exp_port, pld});
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout dut%0d pld %h got no rdy_s required accept", d, pld);
        end else if (expect_now && n != 1) begin
            errors++;
            $display("FAIL accept_stall dut%0d pld %h got %0d cycles required 1", d, pld, n);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_vld = 0; a_dst = 0; a_pld = 0; a_vrdy = 4'b1111;
        b_vld = 0; b_dst = 0; b_pld = 0; b_vrdy = 4'b1111;
        c_vld = 0; c_dst = 0; c_pld = 0; c_vrdy = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld_a", 32'(a_vvld), 0);
        chk("rst_pld_a", a_vpld[2], 0);
        chk("rst_drop_a", 32'(a_drop), 0);
        chk("rst_rdy_s_a", 32'(a_rdy), 1);
        chk("rst_vld_b", 32'(b_vvld), 0);
        @(posedge clk); #1 rst = 1'b0;

        // One-cycle latency to the addressed slot, then a spread of destinations.
        send(0, 4'b0100, 32'hA5, 2, 1);
        a_vld = 0;
        @(negedge clk);
        chk("lat1_vld", 32'(a_vvld), 32'b0100);
        chk("lat1_pld", a_vpld[2], 32'hA5);
        @(posedge clk); #1;
        send(0, 4'b0001, 32'h11, 0, 1);
        send(0, 4'b1000, 32'h22, 3, 1);
        send(0, 4'b0110, 32'h33, 1, 1);
        a_vld = 0;

        // Backpressure on slot 2: second beat waits, order kept.
        @(posedge clk); #1 a_vrdy = 4'b1011;
        send(0, 4'b0100, 32'h1, 2, 1);
        fork
            send(0, 4'b0100, 32'h2, 2, 0);
            begin
                @(negedge clk);
                chk("stall_rdy_s", 32'(a_rdy), 0);
                repeat (2) @(posedge clk);
                #1 a_vrdy[2] = 1'b1;
            end
        join
        a_vld = 0;

        // Zero destination drops and the counter saturates.
        repeat (3) send(0, 4'b0000, 32'hDEAD, -1, 1);
        a_vld = 0;
        chk("drop_cnt3", 32'(a_drop), 3);
        force u0.r_drop_cnt = 16'hFFFD;
        #1 release u0.r_drop_cnt;
        repeat (3) send(0, 4'b0000, 32'hBEEF, -1, 1);
        a_vld = 0;
        chk("drop_sat", 32'(a_drop), 32'hFFFF);

        // Load and drain on slot 1 every cycle.
        for (int k = 0; k < 5; k++) send(0, 4'b0010, 32'h100 + k, 1, 1);
        a_vld = 0;

        // Round-robin: plain rotation, then skipping blocked full slots.
        for (int k = 0; k < 8; k++) send(1, 4'b0000, 32'h200 + k, k % 4, 1);
        b_vld = 0;
        @(posedge clk); #1 b_vrdy = 4'b1010;
        for (int k = 0; k < 6; k++) send(1, 4'b1111, 32'h300 + k, rr_ports[k], 1);
        b_vld = 0;
        chk("rr_drop0", 32'(b_drop), 0);
        @(posedge clk); #1 b_vrdy = 4'b1111;
        repeat (3) @(posedge clk);

        // Reset with two slots full discards them and rewinds the pointer.
        #1 b_vrdy = 4'b0000;
        send(1, 4'b0000, 32'h400, 0, 1);
        send(1, 4'b0000, 32'h401, 1, 1);
        b_vld = 0;
        @(negedge clk);
        chk("pre_rst_vld", 32'(b_vvld), 32'b0011);
        @(posedge clk); #1 rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("rst_mid_vld", 32'(b_vvld), 0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_drop_a2", 32'(a_drop), 0);
        chk("rst_vld_b2", 32'(b_vvld), 0);
        b_vrdy = 4'b1111;
        send(1, 4'b0000, 32'h500, 0, 1);
        b_vld = 0;

        // Pass-through instance: zero latency and ready follows the selected port.
        c_vld = 1; c_dst = 4'b0110; c_pld = 32'h1234; c_vrdy = 4'b1111;
        #1;
        chk("pass_vld", 32'(c_vvld), 32'b0010);
        chk("pass_pld", c_vpld[3], 32'h1234);
        chk("pass_rdy", 32'(c_rdy), 1);
        c_vrdy = 4'b1101;
        #1;
        chk("pass_rdy_blk", 32'(c_rdy), 0);
        chk("pass_vld_blk", 32'(c_vvld), 32'b0010);
        c_dst = 4'b0000;
        #1;
        chk("pass_rdy_drop", 32'(c_rdy), 1);
        chk("pass_vld_drop", 32'(c_vvld), 0);
        c_vld = 0;

        repeat (4) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_empty got %0d pending required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
